// File: rtl/enigma_arbiter.sv
// Two-port QoS arbiter with a 64-entry outstanding-ID scoreboard feeding one registered output stage.
// Optional starvation guard (per-port age counters) is compiled in with `define ENIGMA_ARB_AGING_EN.
module enigma_arbiter #(
  parameter int DATA_W    = 128,
  parameter int AGE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] payload_a,
  input  logic [4:0]        id_a,
  input  logic [1:0]        qos_a,
  input  logic              valid_a,
  output logic              ready_a,
  input  logic [DATA_W-1:0] payload_b,
  input  logic [4:0]        id_b,
  input  logic [1:0]        qos_b,
  input  logic              valid_b,
  output logic              ready_b,
  output logic              valid_c,
  output logic [DATA_W-1:0] payload_c,
  output logic [5:0]        id_c,
  output logic [1:0]        qos_c,
  input  logic              ready_c,
  input  logic              conflict_c,
  input  logic              release_c,
  input  logic [5:0]        releaseid_c,
  output logic [6:0]        outstanding,
  output logic              err_release
);

  if (AGE_LIMIT < 1 || AGE_LIMIT > 15) begin : g_age_limit_check
    $error("enigma_arbiter: AGE_LIMIT must be in 1..15");
  end

  logic [63:0]       sb_q, sb_d;
  logic              rr_last_q, rr_last_d;  // 1: B was granted last
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic [5:0]        id_q, id_d;
  logic [1:0]        qos_q, qos_d;
  logic [6:0]        outst_q, outst_d;
  logic              err_q, err_d;

  logic elig_a, elig_b, stage_free, prefer_a;
  logic grant_a, grant_b, grant_any, rel_hit;

`ifdef ENIGMA_ARB_AGING_EN
  logic [3:0] age_a_q, age_b_q;
  logic       aged_a, aged_b;

  function automatic logic [3:0] age_next(input logic [3:0] age, input logic elig,
                                          input logic won);
    if (won) return 4'd0;
    if (elig && age != 4'hF) return age + 4'd1;
    return age;
  endfunction

  assign aged_a = (age_a_q >= 4'(AGE_LIMIT));
  assign aged_b = (age_b_q >= 4'(AGE_LIMIT));
`endif

  always_comb begin
    elig_a     = valid_a & ~sb_q[{1'b0, id_a}];
    elig_b     = valid_b & ~sb_q[{1'b1, id_b}];
    stage_free = ~valid_q | (ready_c & ~conflict_c);
`ifdef ENIGMA_ARB_AGING_EN
    if (aged_a != aged_b)                prefer_a = aged_a;
    else if (!aged_a && qos_a != qos_b)  prefer_a = (qos_a > qos_b);
    else                                 prefer_a = rr_last_q;
`else
    if (qos_a != qos_b) prefer_a = (qos_a > qos_b);
    else                prefer_a = rr_last_q;
`endif
    // Gated by rst so the combinational readies also read 0 while reset is held.
    grant_a   = ~rst & stage_free & elig_a & (~elig_b | prefer_a);
    grant_b   = ~rst & stage_free & elig_b & (~elig_a | ~prefer_a);
    grant_any = grant_a | grant_b;
    rel_hit   = release_c & sb_q[releaseid_c];
  end

  always_comb begin
    sb_d      = sb_q;
    rr_last_d = rr_last_q;
    valid_d   = valid_q;
    payload_d = payload_q;
    id_d      = id_q;
    qos_d     = qos_q;
    err_d     = release_c & ~sb_q[releaseid_c];
    outst_d   = outst_q + {6'd0, grant_any} - {6'd0, rel_hit};
    if (rel_hit) sb_d[releaseid_c] = 1'b0;
    if (grant_a) begin
      sb_d[{1'b0, id_a}] = 1'b1;
      rr_last_d          = 1'b0;
      valid_d            = 1'b1;
      payload_d          = payload_a;
      id_d               = {1'b0, id_a};
      qos_d              = qos_a;
    end else if (grant_b) begin
      sb_d[{1'b1, id_b}] = 1'b1;
      rr_last_d          = 1'b1;
      valid_d            = 1'b1;
      payload_d          = payload_b;
      id_d               = {1'b1, id_b};
      qos_d              = qos_b;
    end else if (valid_q && ready_c && !conflict_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q      <= '0;
      rr_last_q <= 1'b1;
      valid_q   <= 1'b0;
      payload_q <= '0;
      id_q      <= '0;
      qos_q     <= '0;
      outst_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      sb_q      <= sb_d;
      rr_last_q <= rr_last_d;
      valid_q   <= valid_d;
      payload_q <= payload_d;
      id_q      <= id_d;
      qos_q     <= qos_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
    end
  end

`ifdef ENIGMA_ARB_AGING_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_a_q <= '0;
      age_b_q <= '0;
    end else begin
      age_a_q <= age_next(age_a_q, elig_a, grant_a);
      age_b_q <= age_next(age_b_q, elig_b, grant_b);
    end
  end
`endif

  assign ready_a     = grant_a;
  assign ready_b     = grant_b;
  assign valid_c     = valid_q;
  assign payload_c   = payload_q;
  assign id_c        = id_q;
  assign qos_c       = qos_q;
  assign outstanding = outst_q;
  assign err_release = err_q;

endmodule

// File: tb/tb_enigma_arbiter.sv
// Bench for enigma_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Honours `define ENIGMA_ARB_AGING_EN when the DUT is built with aging.
module tb_enigma_arbiter;
  localparam int AGE_LIMIT = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] payload_a, payload_b, payload_c;
  logic [4:0]   id_a, id_b;
  logic [1:0]   qos_a, qos_b, qos_c;
  logic         valid_a, valid_b, ready_a, ready_b;
  logic         valid_c, ready_c, conflict_c, release_c, err_release;
  logic [5:0]   id_c, releaseid_c;
  logic [6:0]   outstanding;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit           sb_m [64];
  int           outst_m;
  bit           last_b_m;
  int           age_m [2];
  bit           vc_m;
  logic [127:0] pay_m;
  logic [5:0]   idc_m;
  logic [1:0]   qc_m;
  bit           err_m;

  enigma_arbiter #(.DATA_W(128), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .payload_a(payload_a), .id_a(id_a), .qos_a(qos_a), .valid_a(valid_a), .ready_a(ready_a),
    .payload_b(payload_b), .id_b(id_b), .qos_b(qos_b), .valid_b(valid_b), .ready_b(ready_b),
    .valid_c(valid_c), .payload_c(payload_c), .id_c(id_c), .qos_c(qos_c),
    .ready_c(ready_c), .conflict_c(conflict_c),
    .release_c(release_c), .releaseid_c(releaseid_c),
    .outstanding(outstanding), .err_release(err_release)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rand_payload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic reset_model();
    foreach (sb_m[i]) sb_m[i] = 1'b0;
    outst_m  = 0;
    last_b_m = 1'b1;
    age_m[0] = 0;
    age_m[1] = 0;
    vc_m     = 1'b0;
    pay_m    = '0;
    idc_m    = '0;
    qc_m     = '0;
    err_m    = 1'b0;
  endtask

  function automatic bit elig_m(input int p);
    if (p == 0) return valid_a && !sb_m[{1'b0, id_a}];
    return valid_b && !sb_m[{1'b1, id_b}];
  endfunction

  // Winner this cycle: -1 none, 0 port A, 1 port B
  function automatic int pick();
    bit ea = elig_m(0);
    bit eb = elig_m(1);
    int ra = int'(qos_a);
    int rb = int'(qos_b);
    if (vc_m && !(ready_c && !conflict_c)) return -1;
    if (!ea && !eb) return -1;
    if (ea && !eb) return 0;
    if (eb && !ea) return 1;
`ifdef ENIGMA_ARB_AGING_EN
    if (age_m[0] >= AGE_LIMIT && age_m[1] >= AGE_LIMIT) return last_b_m ? 0 : 1;
    if (age_m[0] >= AGE_LIMIT) ra += 100;
    if (age_m[1] >= AGE_LIMIT) rb += 100;
`endif
    if (ra > rb) return 0;
    if (rb > ra) return 1;
    return last_b_m ? 0 : 1;
  endfunction

  task automatic apply(input int w);
    bit e[2];
    e[0] = elig_m(0);
    e[1] = elig_m(1);
    err_m = release_c && !sb_m[releaseid_c];
    if (release_c && sb_m[releaseid_c]) begin
      sb_m[releaseid_c] = 1'b0;
      outst_m--;
    end
    if (w == 0) begin
      sb_m[{1'b0, id_a}] = 1'b1; outst_m++; last_b_m = 1'b0;
      vc_m = 1'b1; pay_m = payload_a; idc_m = {1'b0, id_a}; qc_m = qos_a;
    end else if (w == 1) begin
      sb_m[{1'b1, id_b}] = 1'b1; outst_m++; last_b_m = 1'b1;
      vc_m = 1'b1; pay_m = payload_b; idc_m = {1'b1, id_b}; qc_m = qos_b;
    end else if (vc_m && ready_c && !conflict_c) begin
      vc_m = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      if (w == p) age_m[p] = 0;
      else if (e[p] && age_m[p] < 15) age_m[p]++;
    end
  endtask

  task automatic idle_inputs();
    valid_a = 1'b0; valid_b = 1'b0;
    release_c = 1'b0; conflict_c = 1'b0; ready_c = 1'b1;
  endtask

  task automatic settle(output int w);
    #2;
    w = pick();
  endtask

  task automatic tick(input int w);
    @(posedge clk);
    apply(w);
    #1;
  endtask

  task automatic release_all();
    int w;
    idle_inputs();
    for (int i = 0; i < 64; i++) begin
      if (sb_m[i]) begin
        release_c = 1'b1; releaseid_c = 6'(i);
        settle(w); tick(w);
      end
    end
    release_c = 1'b0;
    settle(w); tick(w);
  endtask

  task automatic test_reset();
    idle_inputs();
    valid_a = 1'b1; id_a = 5'd1; qos_a = 2'd3; payload_a = rand_payload();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (valid_c !== 1'b0) begin errors++; $display("FAIL rst_valid_c: got %b expected 0", valid_c); end
    checks++; if (payload_c !== '0) begin errors++; $display("FAIL rst_payload_c: got %h expected 0", payload_c); end
    checks++; if (id_c !== 6'h00) begin errors++; $display("FAIL rst_id_c: got %h expected 0", id_c); end
    checks++; if (qos_c !== 2'd0) begin errors++; $display("FAIL rst_qos_c: got %0d expected 0", qos_c); end
    checks++; if (ready_a !== 1'b0 || ready_b !== 1'b0) begin errors++; $display("FAIL rst_ready: got a=%b b=%b expected 0 0", ready_a, ready_b); end
    checks++; if (outstanding !== 7'd0) begin errors++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
    checks++; if (err_release !== 1'b0) begin errors++; $display("FAIL rst_err_release: got %b expected 0", err_release); end
    rst = 1'b0;
    valid_a = 1'b0;
    reset_model();
  endtask

  task automatic do_tie(input string tag);
    int w;
    logic [127:0] pa;
    pa = rand_payload();
    valid_a = 1'b1; id_a = 5'd3; qos_a = 2'd1; payload_a = pa;
    valid_b = 1'b1; id_b = 5'd4; qos_b = 2'd1; payload_b = rand_payload();
    settle(w);
    checks++; if (ready_a !== 1'b1 || ready_b !== 1'b0) begin errors++; $display("FAIL %s_first_grant: got a=%b b=%b expected 1 0", tag, ready_a, ready_b); end
    tick(w);
    checks++; if (valid_c !== 1'b1 || id_c !== 6'h03 || payload_c !== pa) begin errors++; $display("FAIL %s_first_beat: got v=%b id=%h expected 1 03", tag, valid_c, id_c); end
    settle(w);
    checks++; if (ready_a !== 1'b0 || ready_b !== 1'b1) begin errors++; $display("FAIL %s_second_grant: got a=%b b=%b expected 0 1", tag, ready_a, ready_b); end
    tick(w);
    checks++; if (id_c !== 6'h24) begin errors++; $display("FAIL %s_second_id: got %h expected 24", tag, id_c); end
    checks++; if (outstanding !== 7'd2) begin errors++; $display("FAIL %s_outstanding: got %0d expected 2", tag, outstanding); end
    release_all();
  endtask

  task automatic test_tie();
    do_tie("tie");
  endtask

  task automatic test_qos();
    int w;
    bit exp_a;
    for (int i = 0; i < 9; i++) begin
      valid_a = 1'b1; id_a = 5'(10 + i); qos_a = 2'd0; payload_a = rand_payload();
      valid_b = 1'b1; id_b = 5'(i);      qos_b = 2'd2; payload_b = rand_payload();
`ifdef ENIGMA_ARB_AGING_EN
      exp_a = (i == 8);
`else
      exp_a = 1'b0;
`endif
      settle(w);
      checks++; if (ready_a !== exp_a || ready_b !== !exp_a) begin errors++; $display("FAIL qos_cycle%0d: got a=%b b=%b expected %b %b", i, ready_a, ready_b, exp_a, !exp_a); end
      tick(w);
    end
    release_all();
  endtask

  task automatic test_scoreboard();
    int w;
    valid_a = 1'b1; id_a = 5'd5; qos_a = 2'd1; payload_a = rand_payload();
    settle(w);
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL sb_issue: got %b expected 1", ready_a); end
    tick(w);
    for (int i = 0; i < 3; i++) begin
      settle(w);
      checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL sb_blocked%0d: got %b expected 0", i, ready_a); end
      tick(w);
    end
    release_c = 1'b1; releaseid_c = 6'h05;
    settle(w);
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL sb_release_cycle: got %b expected 0", ready_a); end
    tick(w);
    release_c = 1'b0;
    settle(w);
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL sb_after_release: got %b expected 1", ready_a); end
    tick(w);
    checks++; if (outstanding !== 7'd1) begin errors++; $display("FAIL sb_outstanding: got %0d expected 1", outstanding); end
    release_all();
  endtask

  task automatic test_stall();
    int w;
    logic [127:0] p;
    p = rand_payload();
    valid_a = 1'b1; id_a = 5'd7; qos_a = 2'd2; payload_a = p;
    settle(w); tick(w);
    checks++; if (valid_c !== 1'b1 || id_c !== 6'h07) begin errors++; $display("FAIL stall_load: got v=%b id=%h expected 1 07", valid_c, id_c); end
    id_a = 5'd8; payload_a = rand_payload();
    valid_b = 1'b1; id_b = 5'd9; qos_b = 2'd3; payload_b = rand_payload();
    conflict_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle(w);
      checks++; if (ready_a !== 1'b0 || ready_b !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got a=%b b=%b expected 0 0", i, ready_a, ready_b); end
      tick(w);
      checks++; if (valid_c !== 1'b1 || payload_c !== p || id_c !== 6'h07 || qos_c !== 2'd2) begin errors++; $display("FAIL stall_hold%0d: got v=%b id=%h q=%0d expected 1 07 2", i, valid_c, id_c, qos_c); end
    end
    valid_a = 1'b0; valid_b = 1'b0; conflict_c = 1'b0;
    settle(w); tick(w);
    checks++; if (valid_c !== 1'b0) begin errors++; $display("FAIL stall_complete: got %b expected 0", valid_c); end
    release_all();
  endtask

  task automatic test_bad_release();
    int w;
    release_c = 1'b1; releaseid_c = 6'h3F;
    settle(w); tick(w);
    release_c = 1'b0;
    checks++; if (err_release !== 1'b1) begin errors++; $display("FAIL badrel_pulse: got %b expected 1", err_release); end
    checks++; if (outstanding !== 7'd0) begin errors++; $display("FAIL badrel_outstanding: got %0d expected 0", outstanding); end
    settle(w); tick(w);
    checks++; if (err_release !== 1'b0) begin errors++; $display("FAIL badrel_one_cycle: got %b expected 0", err_release); end
  endtask

  task automatic test_reset_midflight();
    int w;
    for (int i = 0; i < 5; i++) begin
      valid_a = 1'b1; id_a = 5'(i); qos_a = 2'd1; payload_a = rand_payload();
      settle(w); tick(w);
    end
    valid_a = 1'b0; ready_c = 1'b0;
    checks++; if (valid_c !== 1'b1 || outstanding !== 7'd5) begin errors++; $display("FAIL mid_precond: got v=%b out=%0d expected 1 5", valid_c, outstanding); end
    valid_a = 1'b1; id_a = 5'd20;
    #1 rst = 1'b1;
    #1;
    checks++; if (valid_c !== 1'b0 || payload_c !== '0 || id_c !== 6'h00 || qos_c !== 2'd0) begin errors++; $display("FAIL mid_rst_stage: got v=%b id=%h q=%0d expected 0 0 0", valid_c, id_c, qos_c); end
    checks++; if (outstanding !== 7'd0 || err_release !== 1'b0) begin errors++; $display("FAIL mid_rst_counts: got out=%0d err=%b expected 0 0", outstanding, err_release); end
    checks++; if (ready_a !== 1'b0 || ready_b !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got a=%b b=%b expected 0 0", ready_a, ready_b); end
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    idle_inputs();
    do_tie("mid_tie");
  endtask

  task automatic test_random();
    int w;
    for (int n = 0; n < 400; n++) begin
      valid_a = ($urandom_range(0, 3) != 0); id_a = 5'($urandom_range(0, 3));
      qos_a = 2'($urandom_range(0, 3)); payload_a = rand_payload();
      valid_b = ($urandom_range(0, 3) != 0); id_b = 5'($urandom_range(0, 3));
      qos_b = 2'($urandom_range(0, 3)); payload_b = rand_payload();
      ready_c = ($urandom_range(0, 3) != 0);
      conflict_c = ($urandom_range(0, 3) == 0);
      release_c = ($urandom_range(0, 1) == 1);
      releaseid_c = {1'($urandom_range(0, 1)), 3'b000, 2'($urandom_range(0, 3))};
      settle(w);
      checks++; if (ready_a !== (w == 0) || ready_b !== (w == 1)) begin errors++; $display("FAIL rnd_grant n=%0d: got a=%b b=%b expected %b %b", n, ready_a, ready_b, (w == 0), (w == 1)); end
      tick(w);
      checks++; if (valid_c !== vc_m) begin errors++; $display("FAIL rnd_valid n=%0d: got %b expected %b", n, valid_c, vc_m); end
      if (vc_m) begin
        checks++; if (id_c !== idc_m || qos_c !== qc_m || payload_c !== pay_m) begin errors++; $display("FAIL rnd_beat n=%0d: got id=%h q=%0d expected id=%h q=%0d", n, id_c, qos_c, idc_m, qc_m); end
      end
      checks++; if (outstanding !== 7'(outst_m)) begin errors++; $display("FAIL rnd_outstanding n=%0d: got %0d expected %0d", n, outstanding, outst_m); end
      checks++; if (err_release !== err_m) begin errors++; $display("FAIL rnd_err n=%0d: got %b expected %b", n, err_release, err_m); end
    end
    release_all();
  endtask

  initial begin
    payload_a = '0; payload_b = '0; id_a = '0; id_b = '0; qos_a = '0; qos_b = '0;
    releaseid_c = '0;
    idle_inputs();
    reset_model();
    test_reset();
    test_tie();
    test_qos();
    test_scoreboard();
    test_stall();
    test_bad_release();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
